// File: rtl/approx_umul_pipe_if.sv
// Operand/result handshake bundle for approx_umul_pipe.
// The slave side is the multiplier; the master side is the surrounding tile.
interface approx_umul_pipe_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic             approx;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   prod;
  logic             prod_approx;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, x, y, approx, out_ready,
    input  in_ready, out_valid, prod, prod_approx, txn_count
  );

  modport slave (
    input  in_valid, x, y, approx, out_ready,
    output in_ready, out_valid, prod, prod_approx, txn_count
  );
endinterface

// File: rtl/approx_umul_pipe.sv
// Three-stage approximate/exact unsigned multiplier: operand register, paired-row
// half-adder arrays, final sum. One global advance enable moves the whole pipe.

// One half-adder array combining partial-product rows 2K and 2K+1.
// Column col holds row 2K bit x[col-2K] and row 2K+1 bit x[col-2K-1].
module ha_row #(
  parameter int W      = 8,
  parameter int ELIM_W = 6,
  parameter int K      = 0
) (
  input  logic [W-1:0]   x,
  input  logic           y0,
  input  logic           y1,
  input  logic           approx,
  output logic [2*W-1:0] sum,
  output logic [2*W-1:0] carry
);
  logic [2*W-2:0] s, c;

  // The top column never holds a live bit in any array, so only 2W-1 columns exist.
  for (genvar col = 0; col < 2*W-1; col++) begin : g_col
    localparam int IA = col - 2*K;
    localparam int IB = col - 2*K - 1;
    localparam bit MASKABLE = (col < ELIM_W);
    logic a, b, keep;

    assign keep = !(MASKABLE && approx);

    if (IA >= 0 && IA < W) begin : g_a
      assign a = x[IA] & y0 & keep;
    end else begin : g_na
      assign a = 1'b0;
    end

    if (IB >= 0 && IB < W) begin : g_b
      assign b = x[IB] & y1 & keep;
    end else begin : g_nb
      assign b = 1'b0;
    end

    assign s[col] = a ^ b;
    assign c[col] = a & b;
  end

  assign sum   = {1'b0, s};
  assign carry = {c, 1'b0};
endmodule

module approx_umul_pipe #(
  parameter int W      = 8,
  parameter int ELIM_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  approx_umul_pipe_if.slave bus
);
  localparam int NA = W / 2;

  logic                     adv;
  logic [3:1]               vld_pipe;
  logic [W-1:0]             x_s1, y_s1;
  logic                     ap_s1, ap_s2, ap_s3;
  logic [NA-1:0][2*W-1:0]   sum_c, car_c, sum_s2, car_s2;
  logic [2*W-1:0]           total, prod_s3;
  logic [CNT_W-1:0]         cnt;

  assign adv             = bus.out_ready | ~vld_pipe[3];
  assign bus.in_ready    = adv;
  assign bus.out_valid   = vld_pipe[3];
  assign bus.prod        = prod_s3;
  assign bus.prod_approx = ap_s3;
  assign bus.txn_count   = cnt;

  for (genvar k = 0; k < NA; k++) begin : g_arr
    ha_row #(.W(W), .ELIM_W(ELIM_W), .K(k)) u_ha (
      .x      (x_s1),
      .y0     (y_s1[2*k]),
      .y1     (y_s1[2*k+1]),
      .approx (ap_s1),
      .sum    (sum_c[k]),
      .carry  (car_c[k])
    );
  end

  always_comb begin
    total = '0;
    for (int k = 0; k < NA; k++) total = total + sum_s2[k] + car_s2[k];
  end

  // Bubbles shift with the data; valid bits alone mark which slots are live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      x_s1     <= '0;
      y_s1     <= '0;
      ap_s1    <= 1'b0;
      sum_s2   <= '0;
      car_s2   <= '0;
      ap_s2    <= 1'b0;
      prod_s3  <= '0;
      ap_s3    <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[2:1], bus.in_valid};
      x_s1     <= bus.x;
      y_s1     <= bus.y;
      ap_s1    <= bus.approx;
      sum_s2   <= sum_c;
      car_s2   <= car_c;
      ap_s2    <= ap_s1;
      prod_s3  <= total;
      ap_s3    <= ap_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (vld_pipe[3] & bus.out_ready) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_approx_umul_pipe.sv
// Bench for approx_umul_pipe: four configurations share one stimulus stream and
// are scored against a bit-level masked partial-product sum, plus literal checks.
module tb_approx_umul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b1, approx = 1'b0;
  logic [15:0] xr = '0, yr = '0;
  int checks = 0, errors = 0;

  localparam int WD [4] = '{8, 4, 16, 8};
  localparam int EL [4] = '{6, 0, 14, 15};
  localparam int CW [4] = '{16, 4, 16, 16};

  approx_umul_pipe_if #(.W(8),  .CNT_W(16)) b0 ();
  approx_umul_pipe_if #(.W(4),  .CNT_W(4))  b1 ();
  approx_umul_pipe_if #(.W(16), .CNT_W(16)) b2 ();
  approx_umul_pipe_if #(.W(8),  .CNT_W(16)) b3 ();

  approx_umul_pipe #(.W(8),  .ELIM_W(6),  .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  approx_umul_pipe #(.W(4),  .ELIM_W(0),  .CNT_W(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  approx_umul_pipe #(.W(16), .ELIM_W(14), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  approx_umul_pipe #(.W(8),  .ELIM_W(15), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  assign b0.in_valid = in_valid;  assign b0.out_ready = out_ready;  assign b0.approx = approx;
  assign b1.in_valid = in_valid;  assign b1.out_ready = out_ready;  assign b1.approx = approx;
  assign b2.in_valid = in_valid;  assign b2.out_ready = out_ready;  assign b2.approx = approx;
  assign b3.in_valid = in_valid;  assign b3.out_ready = out_ready;  assign b3.approx = approx;
  assign b0.x = xr[7:0];  assign b0.y = yr[7:0];
  assign b1.x = xr[3:0];  assign b1.y = yr[3:0];
  assign b2.x = xr;       assign b2.y = yr;
  assign b3.x = xr[7:0];  assign b3.y = yr[7:0];

  logic        ov [4], ir [4], pa [4];
  logic [31:0] pr [4];
  logic [15:0] tc [4];
  assign ov[0] = b0.out_valid;  assign ir[0] = b0.in_ready;  assign pa[0] = b0.prod_approx;
  assign ov[1] = b1.out_valid;  assign ir[1] = b1.in_ready;  assign pa[1] = b1.prod_approx;
  assign ov[2] = b2.out_valid;  assign ir[2] = b2.in_ready;  assign pa[2] = b2.prod_approx;
  assign ov[3] = b3.out_valid;  assign ir[3] = b3.in_ready;  assign pa[3] = b3.prod_approx;
  assign pr[0] = 32'(b0.prod);  assign tc[0] = b0.txn_count;
  assign pr[1] = 32'(b1.prod);  assign tc[1] = 16'(b1.txn_count);
  assign pr[2] = b2.prod;       assign tc[2] = b2.txn_count;
  assign pr[3] = 32'(b3.prod);  assign tc[3] = b3.txn_count;

  typedef struct packed {
    logic [3:0][31:0] p;
    logic             ap;
  } exp_t;
  exp_t q [$];
  exp_t e;
  int   hs_count = 0;

  // Reference: add every surviving x[i]&y[j] at weight i+j.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input int w, input int el, input logic ap);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (a[i] && b[j] && !(ap && (i + j) < el)) s = s + (32'(1) << (i + j));
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic ap);
    in_valid = 1'b1; xr = a; yr = b; approx = ap;
    step();
  endtask

  always @(negedge rst_n) begin
    q.delete();
    hs_count = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (ov[0] && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        hs_count++;
      end
      if (in_valid && ir[0]) begin
        for (int d = 0; d < 4; d++) e.p[d] = ref_mul(xr, yr, WD[d], EL[d], approx);
        e.ap = approx;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 1; d < 4; d++) chk($sformatf("valid_agree_d%0d", d), 32'(ov[d]), 32'(ov[0]));
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("txn_d%0d", d), 32'(tc[d]), 32'(hs_count % (1 << CW[d])));
        chk($sformatf("in_ready_d%0d", d), 32'(ir[d]), 32'(out_ready || !ov[0]));
      end
      if (ov[0]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out got=out_valid want=no_output");
        end else begin
          for (int d = 0; d < 4; d++) begin
            chk($sformatf("prod_d%0d", d), pr[d], q[0].p[d]);
            chk($sformatf("mode_d%0d", d), 32'(pa[d]), 32'(q[0].ap));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    step(2);
    rst_n = 1'b1;
    step();
    chk("rst_out_valid", 32'(b0.out_valid), 0);
    chk("rst_prod", 32'(b0.prod), 0);
    chk("rst_txn", 32'(b0.txn_count), 0);
    chk("rst_in_ready", 32'(b0.in_ready), 1);

    // Exact back-to-back; a beat presented in cycle c is visible in cycle c+3.
    beat(255, 255, 0); beat(0, 200, 0);
    chk("ex_latency_early", 32'(b0.out_valid), 0);
    beat(16, 16, 0); in_valid = 1'b0;
    chk("ex1_valid", 32'(b0.out_valid), 1);
    chk("ex1_prod", 32'(b0.prod), 65025);
    step(); chk("ex2_prod", 32'(b0.prod), 0);
    step(); chk("ex3_prod", 32'(b0.prod), 256);
    step(); chk("ex_drained", 32'(b0.out_valid), 0);
    chk("ex_txn", 32'(b0.txn_count), 3);

    // Alternating modes, no bubbles
    beat(255, 255, 1); beat(255, 255, 0); beat(3, 3, 1);
    chk("ap1_prod", 32'(b0.prod), 64704);
    chk("ap1_mode", 32'(b0.prod_approx), 1);
    chk("ap1_elim15", 32'(b3.prod), 0);
    chk("ap1_elim0_w4", 32'(b1.prod), 225);
    beat(16, 16, 1);
    chk("ap2_prod", 32'(b0.prod), 65025);
    chk("ap2_mode", 32'(b0.prod_approx), 0);
    beat(3, 3, 0); in_valid = 1'b0;
    chk("ap3_prod", 32'(b0.prod), 0);
    chk("ap3_mode", 32'(b0.prod_approx), 1);
    step(); chk("ap4_prod", 32'(b0.prod), 256);
    step(); chk("ap5_prod", 32'(b0.prod), 9);
    chk("ap5_mode", 32'(b0.prod_approx), 0);
    step();

    // Backpressure with three beats in flight; a held beat must be ignored
    out_ready = 1'b0;
    beat(7, 9, 0); beat(100, 3, 0); beat(200, 201, 0);
    in_valid = 1'b1; xr = 1; yr = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(b0.out_valid), 1);
      chk("bp_prod", 32'(b0.prod), 63);
      chk("bp_in_ready", 32'(b0.in_ready), 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_rel1", 32'(b0.prod), 63);
    step(); chk("bp_rel2", 32'(b0.prod), 300);
    step(); chk("bp_rel3", 32'(b0.prod), 40200);
    step(); chk("bp_drained", 32'(b0.out_valid), 0);
    chk("bp_txn", 32'(b0.txn_count), 11);

    // Asynchronous reset mid-stream
    beat(11, 13, 0); beat(2, 3, 1); beat(50, 60, 0); in_valid = 1'b0;
    chk("mr_prereset", 32'(b0.prod), 143);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(b0.out_valid), 0);
    chk("mr_prod", 32'(b0.prod), 0);
    chk("mr_txn", 32'(b0.txn_count), 0);
    chk("mr_in_ready", 32'(b0.in_ready), 1);
    chk("mr_mode", 32'(b0.prod_approx), 0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("mr_no_stale", 32'(b0.out_valid), 0);
    end
    beat(5, 6, 0); in_valid = 1'b0;
    step(); chk("mr_latency_early", 32'(b0.out_valid), 0);
    step(); chk("mr_post_prod", 32'(b0.prod), 30);
    chk("mr_post_valid", 32'(b0.out_valid), 1);
    step();

    // Counter wrap on the 4-bit counter
    rst_n = 1'b0; step(2); rst_n = 1'b1; step();
    for (int i = 0; i < 16; i++) beat(16'(i), 16'(i + 1), 0);
    in_valid = 1'b0;
    step(3);
    chk("wrap16_w4", 32'(b1.txn_count), 0);
    chk("wrap16_w8", 32'(b0.txn_count), 16);
    beat(1, 1, 0); in_valid = 1'b0;
    step(3);
    chk("wrap17_w4", 32'(b1.txn_count), 1);
    chk("wrap17_w8", 32'(b0.txn_count), 17);

    // Random soak with random valid/ready
    repeat (800) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      approx    = 1'($urandom_range(0, 1));
      xr        = 16'($urandom);
      yr        = 16'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("soak_drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
